// File: rtl/cipher_pkg.sv
// Shared constants, state type and the character cipher used by the
// encryption/decryption link.
package cipher_pkg;

  localparam logic [8:0] Q          = 9'd225;
  localparam logic [8:0] P          = 9'd227;
  // -Q mod P lifted by one extra P so the 9-bit sum never goes negative.
  localparam logic [8:0] ENC_OFFSET = (P + P) - Q;

  localparam logic [7:0] LOWERCASE_A_CHAR = 8'h61;
  localparam logic [7:0] LOWERCASE_Z_CHAR = 8'h7A;
  localparam logic [7:0] NULL_CHAR        = 8'h00;

  localparam logic [7:0] KEY_MIN = 8'd1;
  localparam logic [7:0] KEY_MAX = 8'd226;

  localparam logic [1:0] MODE_ENCRYPT = 2'b01;
  localparam logic [1:0] MODE_DECRYPT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  function automatic logic [7:0] encrypt_char(input logic [7:0] ptxt, input logic [7:0] key);
    logic [8:0] sum;
    sum = {1'b0, ptxt} + ENC_OFFSET - {1'b0, key};
    if (sum >= P) begin
      return 8'(sum - P);
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage

// File: rtl/cipher_fifo.sv
// Synchronous byte FIFO with a registered head that reads NULL_CHAR when empty.
// No bypass: a push is refused while full even if a pop happens that cycle.
module cipher_fifo
  import cipher_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [7:0]                 i_din,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [7:0]                 o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_head;

  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic [AW-1:0] w_rd_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [7:0]    w_head_nxt;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push_ok = i_push && !w_full;
  assign w_pop_ok  = i_pop && !w_empty;

  // The head register is loaded with whatever entry will be at the front next cycle.
  always_comb begin
    w_rd_nxt    = r_rd_ptr;
    w_count_nxt = r_count;
    w_head_nxt  = NULL_CHAR;
    if (w_pop_ok) begin
      w_rd_nxt = r_rd_ptr + AW'(1);
    end else begin
      w_rd_nxt = r_rd_ptr;
    end
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    if (w_count_nxt == '0) begin
      w_head_nxt = NULL_CHAR;
    end else if (w_push_ok && (w_rd_nxt == r_wr_ptr)) begin
      w_head_nxt = i_din;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= NULL_CHAR;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= NULL_CHAR;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
    end
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/encryption_stream.sv
// Streaming lowercase-text encryptor: latches a key per message, encrypts
// handshaken characters and buffers ciphertext toward the consumer.
module encryption_stream
  import cipher_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       start,
  input  logic [7:0] secret_key,
  input  logic       ptxt_valid,
  input  logic [7:0] ptxt_char,
  output logic       ptxt_ready,
  output logic       ctxt_valid,
  output logic [7:0] ctxt_char,
  input  logic       ctxt_ready,
  output logic       err_invalid_seckey,
  output logic       err_invalid_ptxt_char,
  output logic       busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_key;
  logic          r_err_seckey;
  logic          r_err_ptxt;

  logic          w_ptxt_ready;
  logic          w_key_load;
  logic          w_key_bad;
  logic          w_key_legal;
  logic          w_is_lower;
  logic          w_handshake;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_ctxt_byte;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_head;

  assign w_key_legal = (secret_key >= KEY_MIN) && (secret_key <= KEY_MAX);
  assign w_is_lower  = (ptxt_char >= LOWERCASE_A_CHAR) && (ptxt_char <= LOWERCASE_Z_CHAR);
  assign w_handshake = ptxt_valid && w_ptxt_ready;
  assign w_push      = w_handshake && w_is_lower;
  assign w_pop       = !w_empty && ctxt_ready;
  assign w_ctxt_byte = encrypt_char(ptxt_char, r_key);

  always_comb begin
    w_state_nxt  = r_state;
    w_ptxt_ready = 1'b0;
    w_key_load   = 1'b0;
    w_key_bad    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (mode == MODE_ENCRYPT)) begin
          if (w_key_legal) begin
            w_key_load  = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_key_bad   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_ptxt_ready = !w_full;
        if (mode != MODE_ENCRYPT) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Leaves one cycle after the buffer has emptied.
        if (w_count == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key        <= 8'h00;
      r_err_seckey <= 1'b0;
    end else if (w_key_load) begin
      r_key        <= secret_key;
      r_err_seckey <= 1'b0;
    end else if (w_key_bad) begin
      r_err_seckey <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ptxt <= 1'b0;
    end else begin
      r_err_ptxt <= w_handshake && !w_is_lower;
    end
  end

  cipher_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_ctxt_byte),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign ptxt_ready            = w_ptxt_ready;
  assign ctxt_valid            = !w_empty;
  assign ctxt_char             = w_head;
  assign err_invalid_seckey    = r_err_seckey;
  assign err_invalid_ptxt_char = r_err_ptxt;
  assign busy                  = (r_state != ST_IDLE);

endmodule
